// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch path.
package fetch_pkg;

  localparam int          PC_STEP          = 4;
  localparam logic [1:0]  PC_ALIGN_MASK    = 2'b11;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  localparam int FETCH_PC_W    = 64;
  localparam int FETCH_INSTR_W = 32;

  // Queue entry at the default widths; fetch_unit builds the same layout from its parameters.
  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_PC_W-1:0]    pc;
  } fetch_entry;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO holding fetched {instr, pc} entries; flush empties it in one cycle.
module fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 96
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         push,
  input  logic [ENTRY_W-1:0]           push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [ENTRY_W-1:0]           head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && (count != CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage is never reset; only the pointers and count qualify it.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with credit-based issue, redirect/squash and a decoupling queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               arst_n,
  input  logic               enable,
  input  logic               redirect_valid,
  input  logic [DATA_W-1:0]  redirect_pc,
  output logic               imem_ren,
  output logic [DATA_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [DATA_W-1:0]  out_pc
);

  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [DATA_W-1:0]  pc;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [DATA_W-1:0] align_pc(input logic [DATA_W-1:0] pc);
    return pc & ~DATA_W'(PC_ALIGN_MASK);
  endfunction

  logic [DATA_W-1:0] fetch_pc_p0;
  logic              vld_p1;
  logic [DATA_W-1:0] pc_p1;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic              push;
  logic              pop;
  entry_t            push_entry;
  entry_t            head_entry;

  // The in-flight request holds a queue slot, so its response can always be written.
  assign credit_used = {1'b0, count} + (CNT_W+1)'(vld_p1);
  assign imem_ren    = arst_n & enable & ~redirect_valid &
                       (credit_used < (CNT_W+1)'(DEPTH));
  assign imem_addr   = fetch_pc_p0;

  // Stage p0 -> p1: issue request, advance the fetch address
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      fetch_pc_p0 <= RESET_PC;
      vld_p1      <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= align_pc(redirect_pc);
      vld_p1      <= 1'b0;
    end else begin
      vld_p1 <= imem_ren;
      if (imem_ren) fetch_pc_p0 <= fetch_pc_p0 + DATA_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (imem_ren) pc_p1 <= fetch_pc_p0;
  end

  // Stage p1 -> queue: capture SRAM response unless squashed by redirect
  assign push       = vld_p1 & ~redirect_valid;
  assign push_entry = '{instr: imem_rdata, pc: pc_p1};
  assign pop        = out_valid & out_ready;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_queue (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head_entry)
  );

  assign out_valid = (count != '0);
  assign out_instr = out_valid ? head_entry.instr : '0;
  assign out_pc    = out_valid ? head_entry.pc    : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: SRAM model, expected-PC scoreboard and cycle-exact checks.
module tb_fetch_unit;

  localparam int DATA_W  = 64;
  localparam int INSTR_W = 32;

  logic               clk = 1'b0;
  logic               arst_n;
  logic               enable;
  logic               redirect_valid;
  logic [DATA_W-1:0]  redirect_pc;
  logic               imem_ren;
  logic [DATA_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata = '0;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [DATA_W-1:0]  out_pc;

  int errors = 0;
  int checks = 0;
  logic [63:0] sb[$];

  fetch_unit #(.DATA_W(DATA_W), .INSTR_W(INSTR_W), .DEPTH(4), .RESET_PC('0)) dut (
    .clk            (clk),
    .arst_n         (arst_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_ren       (imem_ren),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h1300_0013 ^ a[31:0] ^ a[63:32];
  endfunction

  always @(posedge clk) begin
    if (imem_ren) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [63:0] start, input int n);
    for (int i = 0; i < n; i++) sb.push_back(start + 64'(4 * i));
  endtask

  // Every accepted handshake must match the next expected PC and its SRAM word.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      logic [63:0] exp_pc;
      check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        exp_pc = sb.pop_front();
        check("mon_pc", out_pc, exp_pc);
        check("mon_instr", 64'(out_instr), 64'(mem_word(exp_pc)));
      end
    end
  end

  initial begin
    int ren_cnt;
    arst_n = 1'b0; enable = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    tick; tick;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr",  imem_addr, 64'h0);
    check("rst_ren",   64'(imem_ren), 64'd0);
    check("rst_pc",    out_pc, 64'h0);
    check("rst_instr", 64'(out_instr), 64'd0);

    // Streaming after reset
    arst_n = 1'b1; enable = 1'b1; out_ready = 1'b1;
    push_stream(64'h0, 40);
    #1;
    check("c0_ren",  64'(imem_ren), 64'd1);
    check("c0_addr", imem_addr, 64'h0);
    tick; #1;
    check("c1_valid", 64'(out_valid), 64'd0);
    tick; #1;
    check("c2_valid", 64'(out_valid), 64'd1);
    check("c2_pc",    out_pc, 64'h0);
    repeat (6) tick;
    #1;
    check("c8_valid", 64'(out_valid), 64'd1);
    check("c8_pc",    out_pc, 64'h18);

    // Backpressure: queue fills with exactly DEPTH requests
    arst_n = 1'b0; out_ready = 1'b0; sb.delete();
    tick;
    arst_n = 1'b1;
    push_stream(64'h0, 40);
    ren_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (imem_ren) ren_cnt++;
      tick;
    end
    #1;
    check("full_reqs",  64'(ren_cnt), 64'd4);
    check("full_ren",   64'(imem_ren), 64'd0);
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_head",  out_pc, 64'h0);
    out_ready = 1'b1;
    repeat (4) tick;
    #1;
    check("drain_pc10", out_pc, 64'h10);
    repeat (4) tick;

    // Redirect with queue holding 3 entries plus one in flight
    arst_n = 1'b0; out_ready = 1'b0; sb.delete();
    tick;
    arst_n = 1'b1;
    repeat (4) tick;
    redirect_valid = 1'b1; redirect_pc = 64'h103;
    #1;
    check("redir_ren0",   64'(imem_ren), 64'd0);
    check("redir_valid0", 64'(out_valid), 64'd1);
    tick;
    redirect_valid = 1'b0; out_ready = 1'b1;
    sb.delete(); push_stream(64'h100, 40);
    #1;
    check("redir_valid1", 64'(out_valid), 64'd0);
    check("redir_ren1",   64'(imem_ren), 64'd1);
    check("redir_addr1",  imem_addr, 64'h100);
    tick; #1;
    check("redir_valid2", 64'(out_valid), 64'd0);
    tick; #1;
    check("redir_valid3", 64'(out_valid), 64'd1);
    check("redir_pc3",    out_pc, 64'h100);
    repeat (3) tick;

    // Redirect during a handshake, then a second redirect right after
    redirect_valid = 1'b1; redirect_pc = 64'h200;
    #1;
    check("b2b_hs_valid", 64'(out_valid), 64'd1);
    tick;
    redirect_pc = 64'h300; sb.delete();
    #1;
    check("b2b_valid1", 64'(out_valid), 64'd0);
    check("b2b_ren1",   64'(imem_ren), 64'd0);
    tick;
    redirect_valid = 1'b0;
    sb.delete(); push_stream(64'h300, 40);
    #1;
    check("b2b_addr", imem_addr, 64'h300);
    check("b2b_ren",  64'(imem_ren), 64'd1);
    tick; tick; #1;
    check("b2b_pc", out_pc, 64'h300);
    repeat (5) tick;

    // Reset with three entries queued
    redirect_valid = 1'b1; redirect_pc = 64'h400; out_ready = 1'b0;
    tick;
    redirect_valid = 1'b0; sb.delete();
    repeat (4) tick;
    #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    check("pre_rst_pc",    out_pc, 64'h400);
    arst_n = 1'b0;
    tick;
    arst_n = 1'b1; out_ready = 1'b1;
    push_stream(64'h0, 40);
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_addr",  imem_addr, 64'h0);
    check("mid_rst_ren",   64'(imem_ren), 64'd1);
    tick; tick; #1;
    check("mid_rst_pc", out_pc, 64'h0);
    repeat (3) tick;

    // Address wrap, then enable low with a request in flight
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick;
    redirect_valid = 1'b0;
    sb.delete(); push_stream(64'hFFFF_FFFF_FFFF_FFFC, 4);
    #1;
    check("wrap_addr0", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_ren0",  64'(imem_ren), 64'd1);
    tick; #1;
    check("wrap_addr1", imem_addr, 64'h0);
    repeat (3) tick;
    enable = 1'b0;
    #1;
    check("dis_ren", 64'(imem_ren), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick; #1;
      check("dis_ren_hold", 64'(imem_ren), 64'd0);
    end
    check("dis_all_delivered", 64'(sb.size()), 64'd0);
    check("dis_valid",         64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
